// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_detect_pkg;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;
    localparam logic [4:0]  PAT_RST_DEFAULT = 5'b10011;

    // Width needed to count 0..pat_w inclusive.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter; a hit on the same edge as a clear leaves the count at 1.
module seq_match_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (hit) begin
            if (clr) begin
                count <= CNT_W'(1);
            end else if (count != '1) begin
                count <= count + 1'b1;
            end
        end else if (clr) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern and optional overlap.
// Match counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W   = 5,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEFAULT,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             inp,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             outp,
    output logic [PAT_W-1:0] stack,
    output logic             primed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  stack_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              match;

    // A load on the same edge suppresses both the shift and any match.
    always_comb begin
        stack_next = {stack[PAT_W-2:0], inp};
        fill_next  = (fill == FILL_FULL) ? fill : fill + 1'b1;
        match      = in_valid && !pat_load && (fill_next == FILL_FULL) && (stack_next == pattern);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stack   <= '0;
            fill    <= '0;
            pattern <= PAT_RST;
            outp    <= 1'b0;
        end else begin
            outp <= match;
            if (pat_load) begin
                pattern <= pat_in;
                fill    <= '0;
            end else if (in_valid) begin
                stack <= stack_next;
                fill  <= (match && !OVERLAP) ? '0 : fill_next;
            end
        end
    end

    assign primed = (fill == FILL_FULL);

`ifdef SEQ_DETECT_CNT_EN
    seq_match_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .hit  (match),
        .clr  (cnt_clr),
        .count(match_cnt)
    );
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: two detector configurations against a bit-history reference model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       inp = 1'b0;
    logic       pat_load = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [4:0] pat_in0 = 5'b10011;
    logic [3:0] pat_in1 = 4'b1011;

    logic       outp0, outp1, primed0, primed1;
    logic [4:0] stack0;
    logic [3:0] stack1;
    logic [7:0] cnt0;
    logic [3:0] cnt1;

    int checks = 0;
    int failures = 0;

`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_detect_param u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .inp      (inp),
        .pat_load (pat_load),
        .pat_in   (pat_in0),
        .cnt_clr  (cnt_clr),
        .outp     (outp0),
        .stack    (stack0),
        .primed   (primed0),
        .match_cnt(cnt0)
    );

    seq_detect_param #(
        .PAT_W  (4),
        .PAT_RST(4'b1011),
        .OVERLAP(1'b0),
        .CNT_W  (4)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .inp      (inp),
        .pat_load (pat_load),
        .pat_in   (pat_in1),
        .cnt_clr  (cnt_clr),
        .outp     (outp1),
        .stack    (stack1),
        .primed   (primed1),
        .match_cnt(cnt1)
    );

    // Reference: "fresh" counts bits accepted since reset, load or a non-overlapping match.
    int m_w[2]      = '{5, 4};
    bit m_ov[2]     = '{1'b1, 1'b0};
    int m_cmax[2]   = '{255, 15};
    int m_rstpat[2] = '{19, 11};
    int m_stack[2];
    int m_fresh[2];
    int m_pat[2];
    int m_cnt[2];
    int m_out[2];
    bit m_hit;

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_stack[i] = 0;
                m_fresh[i] = 0;
                m_pat[i]   = m_rstpat[i];
                m_out[i]   = 0;
                m_cnt[i]   = 0;
            end else begin
                m_hit = 1'b0;
                if (pat_load) begin
                    m_pat[i]   = (i == 0) ? int'(pat_in0) : int'(pat_in1);
                    m_fresh[i] = 0;
                end else if (in_valid) begin
                    m_stack[i] = (m_stack[i] * 2 + int'(inp)) % (1 << m_w[i]);
                    m_fresh[i] = m_fresh[i] + 1;
                    m_hit = (m_fresh[i] >= m_w[i]) && (m_stack[i] == m_pat[i]);
                    if (m_hit && !m_ov[i]) m_fresh[i] = 0;
                end
                m_out[i] = int'(m_hit);
                if (CNT_ON) begin
                    if (m_hit) m_cnt[i] = cnt_clr ? 1 : ((m_cnt[i] < m_cmax[i]) ? m_cnt[i] + 1 : m_cnt[i]);
                    else if (cnt_clr) m_cnt[i] = 0;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed expectation applied to both the DUT and the reference model.
    task automatic lit(input string name, input logic [31:0] dut, input int model, input int exp);
        cmp({name, "_dut"}, dut, exp);
        cmp({name, "_model"}, 32'(model), exp);
    endtask

    always @(negedge clk) begin
        cmp("outp0",   32'(outp0),   m_out[0]);
        cmp("stack0",  32'(stack0),  m_stack[0]);
        cmp("primed0", 32'(primed0), int'(m_fresh[0] >= m_w[0]));
        cmp("cnt0",    32'(cnt0),    m_cnt[0]);
        cmp("outp1",   32'(outp1),   m_out[1]);
        cmp("stack1",  32'(stack1),  m_stack[1]);
        cmp("primed1", 32'(primed1), int'(m_fresh[1] >= m_w[1]));
        cmp("cnt1",    32'(cnt1),    m_cnt[1]);
    end

    task automatic step(input bit v, input bit b, input bit ld = 1'b0, input bit clr = 1'b0);
        in_valid = v;
        inp      = b;
        pat_load = ld;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int k = n - 1; k >= 0; k--) step(1'b1, v[k]);
    endtask

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lit("rst_stack0", 32'(stack0), m_stack[0], 0);
        lit("rst_primed0", 32'(primed0), int'(m_fresh[0] >= 5), 0);
        lit("rst_cnt0", 32'(cnt0), m_cnt[0], 0);

        // Default pattern, continuous stream.
        send(16'b10011, 5);
        lit("dflt_outp", 32'(outp0), m_out[0], 1);
        lit("dflt_stack", 32'(stack0), m_stack[0], 5'b10011);
        lit("dflt_cnt", 32'(cnt0), m_cnt[0], CNT_ON ? 1 : 0);
        step(1'b0, 1'b0);
        lit("dflt_after", 32'(outp0), m_out[0], 0);

        // Same pattern with idle gaps between accepted bits.
        step(1'b0, 1'b0, 1'b1);
        for (int k = 4; k >= 0; k--) begin
            logic [4:0] p;
            p = 5'b10011;
            step(1'b1, p[k]);
            if (k != 0) begin
                repeat (3) step(1'b0, 1'b1);
                lit("gap_outp", 32'(outp0), m_out[0], 0);
            end
        end
        lit("gap_pulse", 32'(outp0), m_out[0], 1);

        // Pattern load after three bits.
        send(16'b101, 3);
        pat_in0 = 5'b11100;
        step(1'b1, 1'b1, 1'b1);
        lit("load_primed", 32'(primed0), int'(m_fresh[0] >= 5), 0);
        send(16'b1110, 4);
        lit("load_nopulse", 32'(outp0), m_out[0], 0);
        send(16'b0, 1);
        lit("load_pulse", 32'(outp0), m_out[0], 1);

        // Non-overlapping 4-bit instance, then overlapping 5-bit instance.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pat_in0 = 5'b10101;
        step(1'b0, 1'b0, 1'b1);
        send(16'b1011, 4);
        lit("novl_first", 32'(outp1), m_out[1], 1);
        send(16'b011, 3);
        lit("novl_second", 32'(outp1), m_out[1], 0);
        lit("novl_cnt", 32'(cnt1), m_cnt[1], CNT_ON ? 1 : 0);
        step(1'b0, 1'b0, 1'b1);
        send(16'b10101, 5);
        lit("ovl_first", 32'(outp0), m_out[0], 1);
        send(16'b01, 2);
        lit("ovl_second", 32'(outp0), m_out[0], 1);

        // Saturation of the 4-bit counter, then clear racing a match.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (20) send(16'b1011, 4);
        lit("sat_cnt", 32'(cnt1), m_cnt[1], CNT_ON ? 15 : 0);
        send(16'b101, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        lit("clr_match_cnt", 32'(cnt1), m_cnt[1], CNT_ON ? 1 : 0);
        lit("clr_match_outp", 32'(outp1), m_out[1], 1);

        // Reset mid-stream discards partial history.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(16'b1001, 4);
        rst = 1'b0;
        step(1'b0, 1'b0);
        rst = 1'b1;
        lit("mid_rst_stack", 32'(stack0), m_stack[0], 0);
        send(16'b1, 1);
        lit("post_rst_first", 32'(outp0), m_out[0], 0);
        lit("post_rst_primed", 32'(primed0), int'(m_fresh[0] >= 5), 0);
        send(16'b0011, 4);
        lit("post_rst_pulse", 32'(outp0), m_out[0], 1);
        lit("post_rst_cnt", 32'(cnt0), m_cnt[0], CNT_ON ? 1 : 0);

        // Randomised traffic with occasional loads, clears and asynchronous resets.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 199);
            if (r < 4) begin
                pat_in0 = 5'($urandom);
                pat_in1 = 4'($urandom);
                step(1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            end else if (r == 4) begin
                #3 rst = 1'b0;
                #3 rst = 1'b1;
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, $urandom_range(0, 40) == 0);
            end
        end
        step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
